tx_buffer: RTL and testbench

TX_BUFFER -- requirements
Module: tx_buffer

---
 rtl/tx_buffer.sv | 154 +++++++++++++++
 tb/tb_tx_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_buffer.sv
// tx_buffer: byte FIFO in front of an AXI-Stream MAC interface.
// Bytes are written one per cycle with a last marker; a frame is only
// transmitted once its last byte is stored. After each frame the output
// stays idle for GAP cycles before the next frame can start.
module tx_buffer #(
  parameter int SIZE = 2048,
  parameter int GAP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btx_valid,
  input  logic [7:0]               btx_data,
  input  logic                     btx_last,
  output logic                     btx_full,
  output logic                     btx_empty,
  output logic [$clog2(SIZE):0]    frames_pending,
  output logic [7:0]               tx_axis_tdata,
  output logic                     tx_axis_tvalid,
  output logic                     tx_axis_tlast,
  input  logic                     tx_axis_tready,
  output logic                     busy
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [8:0]      r_mem [SIZE];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [PW-1:0]   r_frames;
  logic [7:0]      r_tdata;
  logic            r_tlast;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_hs_last;
  logic [8:0]      w_rd_word;
  logic [AW-1:0]   w_wptr_inc;

  assign w_wptr_inc = r_wptr + AW'(1);
  assign btx_full   = (w_wptr_inc == r_rptr);
  assign btx_empty  = (r_wptr == r_rptr);
  assign w_wr_en    = btx_valid & ~btx_full;
  assign w_rd_word  = r_mem[r_rptr];
  assign w_hs_last  = (r_state == S_SEND) & tx_axis_tready & r_tlast;

  assign frames_pending = r_frames;
  assign tx_axis_tdata  = r_tdata;
  assign tx_axis_tlast  = r_tlast;
  assign tx_axis_tvalid = (r_state == S_SEND);
  assign busy           = (r_state != S_IDLE);

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= {btx_last, btx_data};
    end
  end

  // Write and read pointers, wrapping modulo SIZE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= w_wptr_inc;
      if (w_rd_en) r_rptr <= r_rptr + AW'(1);
    end
  end

  // Count of complete frames stored but not yet fully handed to the MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames <= '0;
    end else begin
      case ({w_wr_en & btx_last, w_hs_last})
        2'b10:   r_frames <= r_frames + PW'(1);
        2'b01:   r_frames <= r_frames - PW'(1);
        default: r_frames <= r_frames;
      endcase
    end
  end

  // Output register, reloaded from the buffer head whenever a byte is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else if (w_rd_en) begin
      {r_tlast, r_tdata} <= w_rd_word;
    end
  end

  // Inter-frame gap counter, held at zero outside the GAP state.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_GAP) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and read-enable decode.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_frames != '0) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_rd_en      = 1'b1;
        w_next_state = S_SEND;
      end
      S_SEND: begin
        if (tx_axis_tready) begin
          if (r_tlast) begin
            w_next_state = (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            // Prefetch the next byte on the handshake so bytes go out back-to-back.
            w_rd_en = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_buffer.sv
// Directed testbench for tx_buffer (SIZE=16, GAP=2).
module tb_tx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btx_valid = 1'b0;
  logic [7:0] btx_data = '0;
  logic       btx_last = 1'b0;
  logic       btx_full;
  logic       btx_empty;
  logic [4:0] frames_pending;
  logic [7:0] tx_axis_tdata;
  logic       tx_axis_tvalid;
  logic       tx_axis_tlast;
  logic       tx_axis_tready = 1'b1;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_bytes [32];

  tx_buffer #(.SIZE(16), .GAP(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .btx_valid      (btx_valid),
    .btx_data       (btx_data),
    .btx_last       (btx_last),
    .btx_full       (btx_full),
    .btx_empty      (btx_empty),
    .frames_pending (frames_pending),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tlast  (tx_axis_tlast),
    .tx_axis_tready (tx_axis_tready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    btx_valid = 1'b1;
    btx_data  = d;
    btx_last  = l;
    tick();
    btx_valid = 1'b0;
    btx_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Receive n bytes, comparing against exp_bytes; stall=1 drives tready 1,0,0,...
  task automatic recv(input string tag, input int n, input bit stall);
    int got = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic [7:0] hold_d = '0;
    while (got < n && cyc < 400) begin
      tx_axis_tready = stall ? (cyc % 3 == 0) : 1'b1;
      if (hold) begin
        check({tag, " hold_valid"}, 32'(tx_axis_tvalid), 32'd1);
        check({tag, " hold_data"}, 32'(tx_axis_tdata), 32'(hold_d));
      end
      hold = 1'b0;
      if (tx_axis_tvalid) begin
        if (tx_axis_tready) begin
          check({tag, " data"}, 32'(tx_axis_tdata), 32'(exp_bytes[got]));
          check({tag, " last"}, 32'(tx_axis_tlast), 32'(got == n - 1));
          got++;
        end else begin
          hold   = 1'b1;
          hold_d = tx_axis_tdata;
        end
      end
      tick();
      cyc++;
    end
    check({tag, " byte_count"}, 32'(got), 32'(n));
    tx_axis_tready = 1'b1;
  endtask

  initial begin
    int vcount;
    int low_cnt;
    int idle_cnt;
    int got;

    // Reset state
    do_reset();
    check("rst tvalid", 32'(tx_axis_tvalid), 32'd0);
    check("rst tlast", 32'(tx_axis_tlast), 32'd0);
    check("rst tdata", 32'(tx_axis_tdata), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst empty", 32'(btx_empty), 32'd1);
    check("rst full", 32'(btx_full), 32'd0);
    check("rst frames", 32'(frames_pending), 32'd0);

    // Basic 4-byte frame, tready=1; latency and gap
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h44, 1'b1);
    check("t1 frames_after_write", 32'(frames_pending), 32'd1);
    check("t1 tvalid_n0", 32'(tx_axis_tvalid), 32'd0);
    tick();
    check("t1 tvalid_n1", 32'(tx_axis_tvalid), 32'd0);
    check("t1 busy_load", 32'(busy), 32'd1);
    tick();
    check("t1 tvalid_n2", 32'(tx_axis_tvalid), 32'd1);
    recv("t1", 4, 1'b0);
    check("t1 frames_done", 32'(frames_pending), 32'd0);
    check("t1 gap0_tvalid", 32'(tx_axis_tvalid), 32'd0);
    check("t1 gap0_busy", 32'(busy), 32'd1);
    check("t1 gap_tdata_held", 32'(tx_axis_tdata), 32'h44);
    check("t1 gap_tlast_held", 32'(tx_axis_tlast), 32'd1);
    tick();
    check("t1 gap1_tvalid", 32'(tx_axis_tvalid), 32'd0);
    check("t1 gap1_busy", 32'(busy), 32'd1);
    tick();
    check("t1 idle_busy", 32'(busy), 32'd0);
    check("t1 empty", 32'(btx_empty), 32'd1);

    // Same frame with tready stalls
    wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h44, 1'b1);
    recv("t2", 4, 1'b1);
    tick(); tick(); tick();
    check("t2 frames", 32'(frames_pending), 32'd0);
    check("t2 busy", 32'(busy), 32'd0);
    check("t2 empty", 32'(btx_empty), 32'd1);

    // Partial frame is held until its last byte arrives
    wr(8'hA1, 1'b0); wr(8'hA2, 1'b0); wr(8'hA3, 1'b0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_axis_tvalid) vcount++;
      tick();
    end
    check("t3 partial_tvalid_cycles", 32'(vcount), 32'd0);
    check("t3 partial_frames", 32'(frames_pending), 32'd0);
    check("t3 partial_empty", 32'(btx_empty), 32'd0);
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hA2; exp_bytes[2] = 8'hA3; exp_bytes[3] = 8'h55;
    wr(8'h55, 1'b1);
    recv("t3", 4, 1'b0);
    tick(); tick(); tick();

    // SIZE=16: fill to capacity 15 with tready=0, extra write dropped
    tx_axis_tready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp_bytes[i] = 8'h30 + 8'(i);
      wr(8'h30 + 8'(i), i == 14);
    end
    check("t4 full", 32'(btx_full), 32'd1);
    check("t4 frames_full", 32'(frames_pending), 32'd1);
    wr(8'hEE, 1'b1);
    check("t4 full_after_drop", 32'(btx_full), 32'd1);
    check("t4 frames_after_drop", 32'(frames_pending), 32'd1);
    recv("t4", 15, 1'b0);
    check("t4 empty", 32'(btx_empty), 32'd1);
    check("t4 frames_done", 32'(frames_pending), 32'd0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_axis_tvalid) vcount++;
      tick();
    end
    check("t4 no_extra_bytes", 32'(vcount), 32'd0);

    // Two frames back-to-back: 2 bytes then 3 bytes
    tx_axis_tready = 1'b0;
    exp_bytes[0] = 8'hB0; exp_bytes[1] = 8'hB1;
    exp_bytes[2] = 8'hC0; exp_bytes[3] = 8'hC1; exp_bytes[4] = 8'hC2;
    wr(8'hB0, 1'b0); wr(8'hB1, 1'b1); wr(8'hC0, 1'b0); wr(8'hC1, 1'b0); wr(8'hC2, 1'b1);
    check("t5 frames_two", 32'(frames_pending), 32'd2);
    tx_axis_tready = 1'b1;
    got = 0; low_cnt = 0; idle_cnt = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (tx_axis_tvalid) begin
        check("t5 data", 32'(tx_axis_tdata), 32'(exp_bytes[got]));
        check("t5 last", 32'(tx_axis_tlast), 32'(got == 1 || got == 4));
        got++;
        tick();
        if (got == 2) check("t5 frames_after_f1", 32'(frames_pending), 32'd1);
        if (got == 5) check("t5 frames_after_f2", 32'(frames_pending), 32'd0);
      end else begin
        if (got == 2) begin
          low_cnt++;
          if (!busy) idle_cnt++;
        end
        tick();
      end
    end
    check("t5 byte_count", 32'(got), 32'd5);
    // Between frames: 2 gap cycles, 1 idle, 1 load with tvalid low.
    check("t5 low_cycles_between", 32'(low_cnt), 32'd4);
    check("t5 idle_cycles_between", 32'(idle_cnt), 32'd1);
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of a frame
    wr(8'hD1, 1'b0); wr(8'hD2, 1'b0); wr(8'hD3, 1'b0); wr(8'hD4, 1'b1);
    vcount = 0;
    while (!tx_axis_tvalid && vcount < 20) begin
      tick();
      vcount++;
    end
    check("t6 frame_started", 32'(tx_axis_tvalid), 32'd1);
    tick();
    check("t6 byte2_shown", 32'(tx_axis_tdata), 32'hD2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 tvalid", 32'(tx_axis_tvalid), 32'd0);
    check("t6 frames", 32'(frames_pending), 32'd0);
    check("t6 empty", 32'(btx_empty), 32'd1);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 tdata", 32'(tx_axis_tdata), 32'd0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_axis_tvalid) vcount++;
      tick();
    end
    check("t6 no_residual", 32'(vcount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
